pwm_peripheral: RTL

- Downstream consumer of the SPI register file. Takes the five 8-bit configuration registers and drives 16 output pins.
- Inputs consumed: output enable [15:0], PWM-mode enable [15:0], duty cycle [7:0].
- Each pin is driven one of three ways: static low, static high, or a shared 8-bit PWM waveform.
- The SPI registers change asynchronously to clk, so the block first resynchronises and stability-filters them, then clocks them into a prescaled PWM engine.

---
 rtl/pwm_peripheral.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral fed by the SPI register file: resync + stability filter, prescaled 8-bit PWM engine.
// Optional build macro PWM_SHADOW_DUTY_EN makes duty changes take effect only at frame boundaries.
module pwm_peripheral #(
    parameter int CLK_DIV     = 3000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] en_out,
    input  logic [15:0] en_pwm,
    input  logic [7:0]  duty,
    output logic [15:0] out,
    output logic        frame_start
);

    localparam int CFG_W = 40;

    logic [CFG_W-1:0] sync_q [SYNC_STAGES];
    logic [CFG_W-1:0] sync_last;
    logic             cfg_eq;
    logic             stable_q;
    logic             adopt;
    logic [15:0]      cfg_en_out;
    logic [15:0]      cfg_en_pwm;
    logic [7:0]       active_duty;
    logic [15:0]      presc;
    logic             tick;
    logic [7:0]       pwm_cnt;
    logic             wrap;
    logic             level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {en_out, en_pwm, duty};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A sample is adopted only after the last two stages have matched on two consecutive clocks,
    // so a register caught mid-write by the SPI side never reaches the pins.
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign cfg_eq    = (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]);
    assign adopt     = cfg_eq && stable_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q   <= 1'b0;
            cfg_en_out <= '0;
            cfg_en_pwm <= '0;
        end else begin
            stable_q <= cfg_eq;
            if (adopt) begin
                cfg_en_out <= sync_last[39:24];
                cfg_en_pwm <= sync_last[23:8];
            end
        end
    end

    assign tick = (presc == 16'(CLK_DIV - 1));
    assign wrap = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= tick ? 16'd0 : presc + 16'd1;
            frame_start <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

`ifdef PWM_SHADOW_DUTY_EN
    logic [7:0] cfg_duty;

    // Adopted duty waits in a shadow register; a value adopted on the wrap clock goes straight in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_duty    <= '0;
            active_duty <= '0;
        end else begin
            if (adopt) begin
                cfg_duty <= sync_last[7:0];
            end
            if (wrap) begin
                active_duty <= adopt ? sync_last[7:0] : cfg_duty;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_duty <= '0;
        end else if (adopt) begin
            active_duty <= sync_last[7:0];
        end
    end
`endif

    // Full-scale duty is special-cased so the pin stays high through count 255 and the wrap.
    always_comb begin
        level = 1'b0;
        if (active_duty == 8'hFF) begin
            level = 1'b1;
        end else if (active_duty != 8'h00) begin
            level = (pwm_cnt < active_duty);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= cfg_en_out & (~cfg_en_pwm | {16{level}});
        end
    end

endmodule
